// File: rtl/preco_display_if.sv
// Price handshake between the price computation block and the display driver:
// load/value in, conversion status and the registered BCD result out.
interface preco_display_if;
  logic        load;
  logic [13:0] value;
  logic        busy;
  logic [15:0] bcd;
  logic        overflow;

  modport master (
    output load,
    output value,
    input  busy,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  load,
    input  value,
    output busy,
    output bcd,
    output overflow
  );
endinterface

// File: rtl/preco_display.sv
// Price display driver: sequential double-dabble binary-to-BCD conversion
// followed by a 4-digit active-low seven-segment scan formatted as EE.CC.
module preco_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic           clk,
  input  logic           reset,
  preco_display_if.slave price,
  output logic [6:0]     seg,
  output logic           dp,
  output logic [3:0]     an
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  state_e        state_q, state_d;
  logic [13:0]   shift_q, shift_d;
  logic [15:0]   scratch_q, scratch_d;
  logic [15:0]   scratch_adj;
  logic [3:0]    iter_q, iter_d;
  logic          ovf_flag_q, ovf_flag_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    nib;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    // NOTE: default first, so no branch leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (price.load) state_d = CONV;
      CONV:    if (iter_q == 4'd13) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / datapath ----------------
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    iter_d     = iter_q;
    ovf_flag_d = ovf_flag_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (price.load) begin
          shift_d    = price.value;
          scratch_d  = '0;
          iter_d     = '0;
          ovf_flag_d = (price.value > 14'd9999);
        end
      end
      CONV: begin
        {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
        iter_d               = iter_q + 4'd1;
      end
      DONE: begin
        // Saturated dashes come from overflow_q; 9999 keeps bcd meaningful.
        bcd_d      = ovf_flag_q ? 16'h9999 : scratch_q;
        overflow_d = ovf_flag_q;
      end
      default: ;
    endcase
  end

  assign price.busy     = (state_q != IDLE);
  assign price.bcd      = bcd_q;
  assign price.overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      iter_q     <= '0;
      ovf_flag_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      iter_q     <= iter_d;
      ovf_flag_q <= ovf_flag_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------- Display scan ----------------
  always_comb begin
    refresh_d = (refresh_q == CNT_MAX) ? '0 : refresh_q + CW'(1);
    digit_d   = (refresh_q == CNT_MAX) ? digit_q - 2'd1 : digit_q;
    nib       = bcd_q[{digit_q, 2'b00} +: 4];
    an_d      = ~(4'b0001 << digit_q);
    if (overflow_q) begin
      seg_d = SEG_DASH;
      dp_d  = 1'b1;
    end else begin
      // Leading-zero blanking applies to the tens-of-euros digit only.
      seg_d = (digit_q == 2'd3 && nib == 4'd0) ? SEG_BLANK : seg_code(nib);
      dp_d  = (digit_q != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      digit_q   <= 2'd3;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= 4'b1111;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: doc/preco_display.md
# preco_display

Display driver for the scale's price outputs. It accepts a 14-bit binary price in cents, such as the computed price or the tare price. It converts that value to four BCD digits with a sequential shift-and-add-3 (double-dabble) engine, then time-multiplexes the digits onto a 4-digit active-low seven-segment display formatted as EE.CC euros. It sits downstream of the price computation block and is the only consumer of its price outputs on the board.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit before the scan advances; legal range ≥ 2.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  single-cycle request to capture `value`; honoured only when not busy.
- value  input  14  price in cents, unsigned binary.
- busy  output  1  high while a conversion is in progress.
- bcd  output  16  last converted value as {thousands, hundreds, tens, units} nibbles.
- overflow  output  1  last captured value was > 9999.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit (cents units).

## Operation
- FSM states are IDLE, CONV and DONE.
- IDLE + load: capture `value` into the shift register, clear the BCD scratch, set iteration count to 0, set the overflow flag to (value > 9999), assert busy, go to CONV.
- IDLE, no load: hold.
- CONV, one iteration per clock, for 14 iterations:
  - Add 3 to every scratch nibble ≥ 5.
  - Then shift {scratch, shift register} left by 1.
  - After the 14th iteration go to DONE.
- DONE:
  - If not overflow, register the scratch into `bcd`; if overflow, register 16'h9999 into `bcd`.
  - Register the overflow flag, clear busy, return to IDLE.
- A load while busy is ignored, with no queueing; a load in the DONE cycle is also ignored.
- The display always shows the registered `bcd`/`overflow`, never the scratch registers, so the display never shows a partial result.
- Display scan:
  - A refresh counter runs 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 3→2→1→0→3 (wraps 0→3).
  - Exactly one anode is low at a time.
- Digit rendering, normal mode:
  - Digit 3 is blanked when its nibble is 0 (leading-zero blanking on digit 3 only).
  - Digits 2..0 always render.
  - dp is low only while digit 2 is lit.
- Digit rendering, overflow mode: all four digits show a dash (seg = 0111111), dp high.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Nibbles > 9 cannot occur.

## Timing
- Reset values, forced on the cycle after reset is sampled high:
  - FSM IDLE, busy=0, bcd=16'h0000, overflow=0.
  - Refresh counter 0, digit index 3.
  - an=4'b1111, seg=7'b1111111, dp=1.
- Reset has priority over load.
- Reset mid-conversion aborts the conversion, leaves bcd=0 and discards the captured value.
- Display outputs are registered.
- First anode activation is 1 cycle after reset deasserts: an=0111 (digit 3, blank for 0). Each digit then stays lit REFRESH_DIV cycles.
- Conversion latency: with load sampled at edge N, busy is high after edge N. CONV iterations occupy edges N+1..N+14. DONE updates bcd/overflow and drops busy at edge N+15.
- Latency is fixed at 15 cycles, including for overflow values.
- Back-to-back: the earliest next load is accepted at edge N+16.
- A bcd update takes effect on the currently lit digit at the next clock edge; the scan timing is unaffected.

## Test plan
- reset, then load value=690 → after 15 cycles: bcd=16'h0690, overflow=0, busy low. Scan with REFRESH_DIV=4:
  - an=0111, seg=1111111
  - an=1011, seg=0000010 (6), dp=0
  - an=1101, seg=0010000 (9)
  - an=1110, seg=1000000 (0)
- load value=9999 → bcd=16'h9999, all digits seg=0010000, dp low only on an=1011. load value=0 → bcd=0, displays " 0.00".
- load value=10000 (and 16383) → overflow=1, bcd=16'h9999, every digit seg=0111111, dp=1; then load 5 → overflow=0, bcd=16'h0005.
- load 1234, then load 4321 at cycles N+3 and N+15 → both ignored, bcd=16'h1234 at N+15; load 4321 at N+16 → bcd=16'h4321 at N+31.
- load 1234 after a completed 690, then reset at N+7 → busy=0, bcd=0, an=1111 the next cycle; no later update to 1234.
- REFRESH_DIV=4 → each anode low for exactly 4 consecutive cycles, sequence 3,2,1,0,3; never more than one anode low.
